// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// State encoding, default geometry and write-port indices.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    localparam int WP_LD  = 0;
    localparam int WP_ALU = 1;

endpackage

// File: rtl/regfile_scb_scoreboard.sv
// Per-register busy scoreboard: writes retire a producer, marks issue a new one.
// A mark and a write to the same register in one cycle leave it busy.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;

    // Next busy vector: set wins over clear so a re-issued register stays pending.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt_s[i] =
                (mark_en && (mark_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
                || (busy_r[i]
                    && !(wr_en[WP_LD]  && (wr_addr[WP_LD*ADDR_W  +: ADDR_W] == ADDR_W'(i)))
                    && !(wr_en[WP_ALU] && (wr_addr[WP_ALU*ADDR_W +: ADDR_W] == ADDR_W'(i))));
        end
    end

    // Busy storage, cleared by reset or an init sweep request.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Lookup ports, no bypass of same-cycle clears.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy_r[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Register file with NUM_RD async read ports, two prioritised write ports,
// optional write-to-read bypass, busy scoreboard and sequential init sweep.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_req,
    output logic                       ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_addr
);

    localparam int DEPTH = 2**ADDR_W;

    state_t              state_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic                ready_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic [1:0]          we_s;
    logic [ADDR_W-1:0]   wa_s [2];
    logic [DATA_W-1:0]   wd_s [2];
    logic                mark_s;
    logic                clr_s;
    logic [ADDR_W-1:0]   ra_s [NUM_RD];
    logic [NUM_RD-1:0]   sb_busy_s;

    // Qualified write/mark/clear strobes; a clear request drops same-cycle accesses.
    always_comb begin
        clr_s  = ready_r && clr_req && !reset;
        mark_s = ready_r && !clr_req && !reset && mark_en;
        we_s   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            wa_s[p] = wr_addr[p*ADDR_W +: ADDR_W];
            wd_s[p] = wr_data[p*DATA_W +: DATA_W];
            we_s[p] = wr_en[p] && ready_r && !clr_req && !reset
                      && !((ZERO_REG != 0) && (wa_s[p] == '0));
        end
    end

    // Init/run controller with registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT;
            ptr_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    ptr_r <= ptr_r + ADDR_W'(1);
                    if (ptr_r == '1) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state_r <= INIT;
                        ptr_r   <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= INIT;
                    ptr_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep clears one entry per cycle; in RUN the ALU port is applied last so it wins.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == INIT)) begin
            mem_r[ptr_r] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we_s[p]) begin
                    mem_r[wa_s[p]] <= wd_s[p];
                end
            end
        end
    end

    // Combinational read ports with optional forwarding of this cycle's write.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_s[k] = rd_addr[k*ADDR_W +: ADDR_W];
            if (!ready_r) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((ZERO_REG != 0) && (ra_s[k] == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && we_s[WP_ALU] && (wa_s[WP_ALU] == ra_s[k])) begin
                rd_data[k*DATA_W +: DATA_W] = wd_s[WP_ALU];
            end else if ((BYPASS != 0) && we_s[WP_LD] && (wa_s[WP_LD] == ra_s[k])) begin
                rd_data[k*DATA_W +: DATA_W] = wd_s[WP_LD];
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s[k]];
            end
        end
    end

    assign ready   = ready_r;
    assign rd_busy = sb_busy_s & {NUM_RD{ready_r}};

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr_s),
        .wr_en     (we_s),
        .wr_addr   (wr_addr),
        .mark_en   (mark_s),
        .mark_addr (mark_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (sb_busy_s)
    );

endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
- Parametrised successor to the processor's register file.
- Adds a configurable number of asynchronous read ports, two prioritised write ports and optional write-to-read bypass.
- Adds a per-register busy scoreboard for the multicycle controller, so it can stall on a pending producer.
- Clears storage with a sequential init sweep (one register per cycle) after reset or on request, instead of a single-cycle bulk clear.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; DEPTH = 2**ADDR_W is a derived localparam.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads as zero, is never written and is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; starts an init sweep when ready=1.
- ready  out  1  high when the sweep is done and the block is accepting accesses.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  busy bit for each read address, combinational.
- wr_en  in  2  write enables; port 1 = ALU/writeback, port 0 = memory/load.
- wr_addr  in  2*ADDR_W  packed write addresses.
- wr_data  in  2*DATA_W  packed write data.
- mark_en  in  1  set busy for mark_addr (instruction issue).
- mark_addr  in  ADDR_W  destination register to mark busy.

Behaviour:
- States: INIT, RUN. Pointer ptr is ADDR_W bits wide.
- Reset (reset=1 sampled at an edge): state<=INIT, ptr<=0, ready<=0, all busy bits<=0.
  - Overrides every other input, including mid-sweep and mid-operation.
- INIT, each edge:
  - mem[ptr]<=0, ptr<=ptr+1.
  - When ptr==DEPTH-1: state<=RUN and ready<=1 on the same edge.
  - Result: ready rises on the DEPTH-th edge after reset falls (32 edges at default).
- In INIT, wr_en, mark_en and clr_req are ignored.
- While ready=0, rd_data=0 and rd_busy=0.
- RUN with clr_req=1: state<=INIT, ptr<=0, ready<=0, busy<=0.
  - Writes and marks presented in that same cycle are dropped.
- Writes (RUN): mem[wr_addr[p]]<=wr_data[p] at the edge.
  - Both ports enabled with the same address: port 1 wins.
  - ZERO_REG=1: writes to address 0 are discarded.
- Reads, combinational:
  - rd_data[k] = mem[rd_addr[k]].
  - ZERO_REG=1 and rd_addr[k]==0: 0.
  - BYPASS=1 and a write is enabled this cycle to rd_addr[k] (non-zero when ZERO_REG=1): returns that wr_data, port 1 taking priority.
  - BYPASS=0: the old value is returned until after the edge.
- Scoreboard (RUN), at each edge:
  - Any enabled write clears busy[wr_addr[p]].
  - mark_en sets busy[mark_addr].
  - mark_en and a write to the same address in one cycle: the mark wins and busy ends at 1 (new producer).
  - ZERO_REG=1: a mark of address 0 is ignored.
- rd_busy[k] = busy[rd_addr[k]], with no bypass.
  - A write clearing busy is visible the cycle after the edge.
- Widths:
  - All addresses are unsigned; there is no out-of-range case because DEPTH = 2**ADDR_W.
  - ptr wraps naturally and is not used outside INIT.

Decomposition:
- Shared defines/package regfile_pkg:
  - INIT/RUN state encoding.
  - Default DATA_W and ADDR_W, consistent with the existing REG_SIZE.
  - Write-port index constants WP_LD=0, WP_ALU=1.
- One sub-module, reg_scoreboard:
  - Holds the DEPTH busy bits and the set/clear priority logic.
  - Has its own reset/clear input.
  - Has NUM_RD lookup outputs.
- Storage, the init FSM and the bypass muxes stay in the top module.

Test Plan:
- Reset sweep: assert reset for 2 cycles, then release → ready=0 for 31 edges, ready=1 on edge 32; all reads return 0.
- Dual write collision: wr_en=2'b11, both addresses 5, data port0=0xAAAA_0000 and port1=0x1234_5678 → after the edge, reg 5 reads 0x1234_5678. In the same cycle with BYPASS=1, rd_addr=5 already reads 0x1234_5678.
- Zero register: write 0xDEAD_BEEF to address 0 and mark_en with mark_addr=0 → rd_data=0, rd_busy=0.
- Scoreboard: mark reg 9 → rd_busy=1 from the next cycle. Then write reg 9 and mark reg 9 in the same cycle → busy stays 1. A lone write to reg 9 → busy=0 the following cycle.
- clr_req mid-run: fill regs 1..31 with their index, then pulse clr_req with a write to reg 3 in the same cycle → ready=0 for 32 edges, every register reads 0 afterwards, and the write is dropped.
- Reset mid-sweep: reset at sweep cycle 10 → the sweep restarts from ptr=0 and ready rises 32 edges after reset falls.
